mem_loader: RTL and testbench

MEM_LOADER -- requirements
Module: mem_loader

---
 rtl/mem_loader_pkg.sv | 30 +++
 rtl/byte_packer.sv | 37 +++
 rtl/mem_loader.sv | 147 ++++++++++++++
 tb/tb_mem_loader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the external memory loader:
// FSM state encoding, word geometry and the little-endian byte-insert helper.
package mem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    FINISH  = 3'd3,
    ERROR   = 3'd4
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADR_STRIDE = 4;
  localparam int WORD_W     = 8 * WORD_BYTES;
  localparam int BCNT_W     = $clog2(WORD_BYTES);

  // Place byte `data` into lane `idx` of `word`; lane k occupies bits [8k+7:8k].
  function automatic logic [WORD_W-1:0] insert_byte(
    input logic [WORD_W-1:0] word,
    input logic [BCNT_W-1:0] idx,
    input logic [7:0]        data
  );
    logic [WORD_W-1:0] res;
    res = word;
    res[8*idx +: 8] = data;
    return res;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes little-endian into a 32-bit word; o_word/o_word_full are
// combinational on the accepting cycle so the FSM can enter WRITE on the next edge.
module byte_packer
  import mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_accept,
  input  logic [7:0]        i_data,
  input  logic              i_clear,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_full
);

  logic [BCNT_W-1:0] r_cnt;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] w_word_next;

  assign w_word_next = insert_byte(r_word, r_cnt, i_data);
  assign o_word      = i_accept ? w_word_next : r_word;
  assign o_word_full = i_accept && (r_cnt == BCNT_W'(WORD_BYTES - 1));

  // The lane counter wraps to 0 on the last byte, so a full word leaves it ready for the next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_accept) begin
      r_cnt  <= r_cnt + 1'b1;
      r_word <= w_word_next;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Streams bytes into 32-bit words and writes them to data memory while holding the CPU in reset.
// One write cycle per word (4 bytes per 5 cycles sustained); in_ready drops outside COLLECT.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_adr,
  input  logic [15:0] word_count,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        cpu_reset,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_DataAdr,
  output logic [31:0] Ext_WriteData,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            r_state;
  logic [15:0]       r_count;
  logic [15:0]       r_word_idx;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [31:0]       r_adr;
  logic [31:0]       r_wdata;
  logic              r_mem_write;
  logic              r_cpu_reset;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic              w_start_ok;
  logic              w_clear;
  logic              w_word_full;
  logic [31:0]       w_packed;

  assign in_ready   = (r_state == COLLECT);
  assign w_accept   = in_valid && in_ready;
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == ERROR));
  assign w_clear    = (r_state == WRITE) || (r_state == ERROR) || w_start_ok;

  byte_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .i_accept    (w_accept),
    .i_data      (in_data),
    .i_clear     (w_clear),
    .o_word      (w_packed),
    .o_word_full (w_word_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_word_idx  <= '0;
      r_idle_cnt  <= '0;
      r_adr       <= '0;
      r_wdata     <= '0;
      r_mem_write <= 1'b0;
      r_cpu_reset <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_write <= 1'b0;
      r_done      <= 1'b0;
      unique case (r_state)
        IDLE, ERROR: begin
          if (start) begin
            r_count     <= word_count;
            r_word_idx  <= '0;
            r_idle_cnt  <= '0;
            r_adr       <= base_adr;
            r_err       <= 1'b0;
            r_busy      <= 1'b1;
            r_cpu_reset <= 1'b1;
            if (word_count == 16'd0) begin
              r_state <= FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (w_word_full) begin
            r_state     <= WRITE;
            r_mem_write <= 1'b1;
            r_wdata     <= w_packed;
            r_idle_cnt  <= '0;
          end else if (w_accept) begin
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
            // Abandon the partial word; cpu_reset stays high so a broken image never runs.
            r_state <= ERROR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_adr   <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        WRITE: begin
          if (r_word_idx == r_count - 16'd1) begin
            r_state <= FINISH;
            r_done  <= 1'b1;
          end else begin
            r_state    <= COLLECT;
            r_word_idx <= r_word_idx + 16'd1;
            r_adr      <= r_adr + 32'(ADR_STRIDE);
            r_idle_cnt <= '0;
          end
        end
        FINISH: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_cpu_reset <= 1'b0;
          r_adr       <= '0;
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_cpu_reset <= 1'b0;
          r_adr       <= '0;
        end
      endcase
    end
  end

  assign Ext_MemWrite  = r_mem_write;
  assign Ext_DataAdr   = r_adr;
  assign Ext_WriteData = r_wdata;
  assign cpu_reset     = r_cpu_reset;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: normal load, empty load, timeout/restart, address wrap, mid-load reset.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_adr;
  logic [15:0] word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        cpu_reset;
  logic        Ext_MemWrite;
  logic [31:0] Ext_DataAdr;
  logic [31:0] Ext_WriteData;
  logic        busy;
  logic        done;
  logic        err;

  mem_loader #(.TIMEOUT_CYCLES(8)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .start         (start),
    .base_adr      (base_adr),
    .word_count    (word_count),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .cpu_reset     (cpu_reset),
    .Ext_MemWrite  (Ext_MemWrite),
    .Ext_DataAdr   (Ext_DataAdr),
    .Ext_WriteData (Ext_WriteData),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Event recorder, sampled on the falling edge.
  logic [31:0] wr_adr [$];
  logic [31:0] wr_dat [$];
  int          wr_cyc [$];
  int done_cnt = 0, done_cyc = -1, fall_cyc = -1, rise_cyc = -1;
  int err_rise_cyc = -1, err_fall_cyc = -1, ready_in_write = 0;
  logic prev_cpu = 1'b0, prev_err = 1'b0;

  always @(negedge clk) begin
    if (Ext_MemWrite) begin
      wr_adr.push_back(Ext_DataAdr);
      wr_dat.push_back(Ext_WriteData);
      wr_cyc.push_back(cyc);
      if (in_ready) ready_in_write++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (prev_cpu && !cpu_reset) fall_cyc = cyc;
    if (!prev_cpu && cpu_reset) rise_cyc = cyc;
    if (!prev_err && err) err_rise_cyc = cyc;
    if (prev_err && !err) err_fall_cyc = cyc;
    prev_cpu = cpu_reset;
    prev_err = err;
  end

  logic [7:0] bytes_q [8];

  // Pulse start, then offer bytes continuously (advancing on handshake) for ncyc cycles.
  // s = cycle stamp of the edge that sampled start.
  task automatic run_load(input logic [31:0] base, input logic [15:0] wc,
                          input logic [7:0] b [8], input int nb, input int ncyc,
                          output int s);
    int idx;
    idx = 0;
    @(negedge clk);
    start = 1'b1; base_adr = base; word_count = wc;
    in_valid = 1'b0;
    @(negedge clk);
    s = cyc;
    start = 1'b0;
    repeat (ncyc) begin
      if (idx < nb) begin
        in_valid = 1'b1;
        in_data  = b[idx];
        if (in_ready) idx++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; base_adr = '0; word_count = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({cpu_reset, busy, done, err, Ext_MemWrite, in_ready} !== 6'b0)
      $display("FAIL reset_flags: got %b expected 000000", {cpu_reset, busy, done, err, Ext_MemWrite, in_ready});
    else n_pass++;
    n_checks++;
    if (Ext_DataAdr !== 32'h0) $display("FAIL reset_adr: got %h expected 00000000", Ext_DataAdr);
    else n_pass++;
    n_checks++;
    if (Ext_WriteData !== 32'h0) $display("FAIL reset_wdata: got %h expected 00000000", Ext_WriteData);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_two_words;
    int s, w0, d0;
    w0 = wr_adr.size(); d0 = done_cnt;
    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(32'h100, 16'd2, bytes_q, 8, 14, s);
    n_checks++;
    if (wr_adr.size() - w0 !== 2) $display("FAIL two_words_count: got %0d expected 2", wr_adr.size() - w0);
    else n_pass++;
    if (wr_adr.size() >= w0 + 2) begin
      n_checks++;
      if (wr_adr[w0] !== 32'h100 || wr_dat[w0] !== 32'h44332211)
        $display("FAIL two_words_w0: got %h@%h expected 44332211@00000100", wr_dat[w0], wr_adr[w0]);
      else n_pass++;
      n_checks++;
      if (wr_adr[w0+1] !== 32'h104 || wr_dat[w0+1] !== 32'h88776655)
        $display("FAIL two_words_w1: got %h@%h expected 88776655@00000104", wr_dat[w0+1], wr_adr[w0+1]);
      else n_pass++;
      n_checks++;
      if (wr_cyc[w0] - s !== 4 || wr_cyc[w0+1] - s !== 9)
        $display("FAIL two_words_timing: got %0d,%0d expected 4,9", wr_cyc[w0] - s, wr_cyc[w0+1] - s);
      else n_pass++;
    end
    n_checks++;
    if (done_cnt - d0 !== 1 || done_cyc - s !== 10)
      $display("FAIL two_words_done: got count %0d at +%0d expected 1 at +10", done_cnt - d0, done_cyc - s);
    else n_pass++;
    n_checks++;
    if (fall_cyc - s !== 11) $display("FAIL two_words_cpu_fall: got +%0d expected +11", fall_cyc - s);
    else n_pass++;
    n_checks++;
    if (ready_in_write !== 0) $display("FAIL ready_in_write: got %0d expected 0", ready_in_write);
    else n_pass++;
    n_checks++;
    if ({cpu_reset, busy, err, Ext_DataAdr} !== 35'h0)
      $display("FAIL two_words_idle: got %h expected 0", {cpu_reset, busy, err, Ext_DataAdr});
    else n_pass++;
  endtask

  task automatic test_zero_words;
    int s, w0, d0;
    w0 = wr_adr.size(); d0 = done_cnt;
    run_load(32'h200, 16'd0, bytes_q, 0, 4, s);
    n_checks++;
    if (wr_adr.size() !== w0) $display("FAIL zero_words_writes: got %0d expected 0", wr_adr.size() - w0);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 !== 1 || done_cyc !== s)
      $display("FAIL zero_words_done: got count %0d at +%0d expected 1 at +0", done_cnt - d0, done_cyc - s);
    else n_pass++;
    n_checks++;
    if (rise_cyc !== s || fall_cyc !== s + 1)
      $display("FAIL zero_words_cpu: got rise +%0d fall +%0d expected +0 +1", rise_cyc - s, fall_cyc - s);
    else n_pass++;
  endtask

  task automatic test_timeout;
    int s, w0, d0;
    w0 = wr_adr.size(); d0 = done_cnt;
    bytes_q = '{8'hA1, 8'hA2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(32'h300, 16'd1, bytes_q, 2, 12, s);
    n_checks++;
    if (err_rise_cyc - s !== 10) $display("FAIL timeout_when: got +%0d expected +10", err_rise_cyc - s);
    else n_pass++;
    n_checks++;
    if ({err, cpu_reset, busy, in_ready, done} !== 5'b11000)
      $display("FAIL timeout_flags: got %b expected 11000", {err, cpu_reset, busy, in_ready, done});
    else n_pass++;
    n_checks++;
    if (wr_adr.size() !== w0 || done_cnt !== d0)
      $display("FAIL timeout_no_write: got writes %0d dones %0d expected 0 0", wr_adr.size() - w0, done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_restart;
    int s, w0;
    w0 = wr_adr.size();
    bytes_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(32'h400, 16'd1, bytes_q, 4, 8, s);
    n_checks++;
    if (err_fall_cyc !== s) $display("FAIL restart_err_clear: got +%0d expected +0", err_fall_cyc - s);
    else n_pass++;
    n_checks++;
    if (wr_adr.size() !== w0 + 1) $display("FAIL restart_count: got %0d expected 1", wr_adr.size() - w0);
    else if (wr_dat[w0] !== 32'hDDCCBBAA || wr_adr[w0] !== 32'h400)
      $display("FAIL restart_write: got %h@%h expected ddccbbaa@00000400", wr_dat[w0], wr_adr[w0]);
    else n_pass++;
    n_checks++;
    if (done_cyc - s !== 5 || fall_cyc - s !== 6 || err !== 1'b0)
      $display("FAIL restart_end: got done +%0d fall +%0d err %b expected +5 +6 0", done_cyc - s, fall_cyc - s, err);
    else n_pass++;
  endtask

  task automatic test_wrap;
    int s, w0;
    w0 = wr_adr.size();
    bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load(32'hFFFFFFFC, 16'd2, bytes_q, 8, 14, s);
    n_checks++;
    if (wr_adr.size() !== w0 + 2) $display("FAIL wrap_count: got %0d expected 2", wr_adr.size() - w0);
    else if (wr_adr[w0] !== 32'hFFFFFFFC || wr_dat[w0] !== 32'h04030201)
      $display("FAIL wrap_w0: got %h@%h expected 04030201@fffffffc", wr_dat[w0], wr_adr[w0]);
    else n_pass++;
    n_checks++;
    if (wr_adr.size() !== w0 + 2) $display("FAIL wrap_count1: got %0d expected 2", wr_adr.size() - w0);
    else if (wr_adr[w0+1] !== 32'h0 || wr_dat[w0+1] !== 32'h08070605)
      $display("FAIL wrap_w1: got %h@%h expected 08070605@00000000", wr_dat[w0+1], wr_adr[w0+1]);
    else n_pass++;
  endtask

  task automatic test_reset_midload;
    int w0, d0;
    w0 = wr_adr.size(); d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; base_adr = 32'h500; word_count = 16'd2; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    @(negedge clk);
    in_data = 8'h22; start = 1'b1; base_adr = 32'h900; word_count = 16'd0;
    @(negedge clk);
    start = 1'b0; in_data = 8'h33;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b1 || Ext_DataAdr !== 32'h500 || done_cnt !== d0)
      $display("FAIL start_ignored: got busy %b adr %h dones %0d expected 1 00000500 0", busy, Ext_DataAdr, done_cnt - d0);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cpu_reset, busy, done, err, Ext_MemWrite, in_ready} !== 6'b0)
      $display("FAIL midload_flags: got %b expected 000000", {cpu_reset, busy, done, err, Ext_MemWrite, in_ready});
    else n_pass++;
    n_checks++;
    if (Ext_DataAdr !== 32'h0 || Ext_WriteData !== 32'h0)
      $display("FAIL midload_buses: got %h %h expected 0 0", Ext_DataAdr, Ext_WriteData);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (wr_adr.size() !== w0 || done_cnt !== d0 || cpu_reset !== 1'b0)
      $display("FAIL midload_after: got writes %0d dones %0d cpu %b expected 0 0 0", wr_adr.size() - w0, done_cnt - d0, cpu_reset);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_words();
    test_timeout();
    test_restart();
    test_wrap();
    test_reset_midload();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
